ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative 32-bit multiply/divide unit for the execute stage. Consumes the operand pair and operation code that the ID/EX pipeline register presents to EX, and returns a 64-bit result to EX/MEM. While an operation is in flight it holds the pipeline through a stall output that freezes the upstream stages.

## Interface
Parameters:
- None. Widths are fixed at 32-bit operands and a 64-bit result, split into Lo and Hi.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  2  operation code; `MD_MUL`, `MD_MULU`, `MD_DIV`, `MD_DIVU`.
- operandA  in  32  multiplicand or dividend (ID/EX registerFileDataA).
- operandB  in  32  multiplier or divisor (ID/EX registerFileDataB).
- flush  in  1  cancels an in-flight op; no done is produced.
- busy  out  1  registered; high whenever state is not IDLE.
- stall  out  1  combinational; `(start & idle & ~flush) | busy`.
- done  out  1  registered one-cycle pulse; result valid.
- resultLo  out  32  low product, or quotient.
- resultHi  out  32  high product, or remainder.

## Operation
- States: IDLE, RUN, FIXUP.
- IDLE + start (flush low):
  - Latch op and the operand magnitudes. Magnitudes are two's-complement absolute values for MUL/DIV; operands are taken raw for MULU/DIVU.
  - Record negRes = signA^signB and negRem = signA (both 0 for unsigned ops).
  - Load counter = 31, clear the accumulator, go to RUN.
- IDLE + start, divide op, operandB == 0: go straight to FIXUP with the divide-by-zero result.
  - resultLo = 0xFFFFFFFF.
  - resultHi = operandA, unmodified.
- RUN, multiply: unsigned shift-add, one multiplier bit per cycle, LSB first, into a 64-bit accumulator.
- RUN, divide: restoring division on a 33-bit partial remainder, one quotient bit per cycle, MSB first.
- RUN exit: when counter == 0 the current iteration is the last; go to FIXUP. Otherwise decrement the counter.
- FIXUP, multiply: if negRes, apply 64-bit two's-complement negation.
- FIXUP, divide:
  - If negRes, negate the quotient.
  - If negRem, negate the remainder.
- FIXUP exit: write resultLo/resultHi, pulse done, return to IDLE.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF falls out of the algorithm as quotient 0x80000000, remainder 0. No special case.
- start outside IDLE is ignored; the pipeline is already stalled.
- Results hold their value until the next FIXUP or reset.

## Timing
- Reset:
  - state = IDLE, counter = 0.
  - busy = 0, done = 0.
  - resultLo = 0, resultHi = 0.
  - Reset mid-operation aborts with no done pulse.
- Accept edge E0 (IDLE with start high). RUN iterations occur at E1..E32. FIXUP at E33 loads the result and sets done = 1. The done pulse spans E33–E34.
- Normal latency is therefore 33 cycles.
- Divide by zero: FIXUP at E1, so done spans E1–E2.
- busy is high from E0 through E33 and drops at E33, the same edge done rises.
- stall is high in the start cycle and every cycle busy is high. EX uses done to capture the result.
- flush in RUN or FIXUP: next edge goes to IDLE, busy = 0, done stays 0, results unchanged.
- flush and start in the same cycle: flush wins; the start is dropped.
- reset has priority over flush and start.
- A new start is accepted in the cycle where done is high.

## Structure
- The shared package `lapido_pkg` holds:
  - op encodings: `MD_MUL` = 2'b00, `MD_MULU` = 2'b01, `MD_DIV` = 2'b10, `MD_DIVU` = 2'b11;
  - state encodings: IDLE = 2'b00, RUN = 2'b01, FIXUP = 2'b10;
  - `MD_ITER` = 32.
- Single module; no sub-module. The magnitude and negate logic is small and lives inline as functions.

## Test plan
- MULU 0xFFFFFFFF × 0xFFFFFFFF → done 33 cycles after accept; resultLo = 0x00000001, resultHi = 0xFFFFFFFE. busy and stall are high throughout.
- MUL 0xFFFFFFFD (−3) × 7 → resultLo = 0xFFFFFFEB, resultHi = 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → resultLo = 0xFFFFFFFD, resultHi = 0xFFFFFFFF. DIVU 100 / 7 → resultLo = 14, resultHi = 2.
- DIVU 100 / 0 → done 1 cycle after accept; resultLo = 0xFFFFFFFF, resultHi = 100. Also DIV 0x80000000 / 0xFFFFFFFF → resultLo = 0x80000000, resultHi = 0.
- MUL started, then reset asserted at cycle 10 → busy = 0, results = 0, no done pulse; a fresh start is accepted next cycle and completes normally.
- flush at cycle 5 of a DIV, and flush coincident with start → busy low the next cycle, no done, prior results unchanged. A start pulsed while busy has no effect on the running op.

Source files
------------

// File: rtl/lapido_pkg.sv
// Shared encodings for the lapido execute-stage multiply/divide unit.
package lapido_pkg;

  localparam logic [1:0] MD_MUL  = 2'b00;
  localparam logic [1:0] MD_MULU = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;
  localparam logic [1:0] MD_DIVU = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FIXUP = 2'b10
  } md_state_e;

  localparam int MD_ITER  = 32;
  localparam int MD_CNT_W = $clog2(MD_ITER);

endpackage

// File: rtl/ex_muldiv.sv
// Iterative 32x32 multiply / 32/32 divide: one bit per cycle on magnitudes,
// sign correction in a final FIXUP cycle. Stalls the pipeline while busy.
module ex_muldiv
  import lapido_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] resultLo,
  output logic [31:0] resultHi
);

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  md_state_e             r_state;
  md_state_e             w_state_next;
  logic                  r_is_div;
  logic [31:0]           r_a;
  logic [31:0]           r_b;
  logic [63:0]           r_acc;
  logic [MD_CNT_W-1:0]   r_cnt;
  logic                  r_neg_res;
  logic                  r_neg_rem;
  logic                  r_busy;
  logic                  r_done;
  logic [31:0]           r_res_lo;
  logic [31:0]           r_res_hi;

  logic        w_idle;
  logic        w_accept;
  logic        w_op_div;
  logic        w_op_signed;
  logic        w_div_zero;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_rem_shift;
  logic [32:0] w_rem_diff;
  logic [63:0] w_div_next;
  logic [63:0] w_prod_fix;
  logic [31:0] w_fix_lo;
  logic [31:0] w_fix_hi;

  assign w_idle      = (r_state == IDLE);
  assign w_accept    = start & w_idle & ~flush;
  assign w_op_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign w_op_signed = (op == MD_MUL) || (op == MD_DIV);
  assign w_div_zero  = w_op_div && (operandB == 32'd0);
  assign w_mag_a     = w_op_signed ? abs32(operandA) : operandA;
  assign w_mag_b     = w_op_signed ? abs32(operandB) : operandB;

  // Shift-add: high half accumulates, product bits shift down into the low half.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_b[0] ? r_a : 32'd0)};
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

  // Restoring divide: acc = {remainder, dividend/quotient shift register}.
  assign w_rem_shift = {r_acc[63:32], r_acc[31]};
  assign w_rem_diff  = w_rem_shift - {1'b0, r_b};
  assign w_div_next  = w_rem_diff[32] ? {w_rem_shift[31:0], r_acc[30:0], 1'b0}
                                      : {w_rem_diff[31:0],  r_acc[30:0], 1'b1};

  assign w_prod_fix = r_neg_res ? neg64(r_acc) : r_acc;

  always_comb begin
    w_fix_lo = w_prod_fix[31:0];
    w_fix_hi = w_prod_fix[63:32];
    if (r_is_div) begin
      w_fix_lo = r_neg_res ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
      w_fix_hi = r_neg_rem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_div_zero ? FIXUP : RUN;
      RUN: begin
        if (flush)              w_state_next = IDLE;
        else if (r_cnt == '0)   w_state_next = FIXUP;
      end
      FIXUP:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_is_div  <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_res_lo  <= '0;
      r_res_hi  <= '0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_state_next != IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_is_div  <= w_op_div;
            r_a       <= w_mag_a;
            r_b       <= w_mag_b;
            r_cnt     <= MD_CNT_W'(MD_ITER - 1);
            r_neg_res <= w_op_signed & (operandA[31] ^ operandB[31]);
            r_neg_rem <= w_op_signed & operandA[31];
            if (w_div_zero) begin
              // Pre-load the divide-by-zero answer; FIXUP passes it through unsigned.
              r_acc     <= {operandA, 32'hFFFF_FFFF};
              r_neg_res <= 1'b0;
              r_neg_rem <= 1'b0;
            end else if (w_op_div) begin
              r_acc <= {32'd0, w_mag_a};
            end else begin
              r_acc <= '0;
            end
          end
        end
        RUN: begin
          if (!flush) begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            if (!r_is_div) r_b <= {1'b0, r_b[31:1]};
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          end else begin
            r_cnt <= '0;
          end
        end
        FIXUP: begin
          if (!flush) begin
            r_res_lo <= w_fix_lo;
            r_res_hi <= w_fix_hi;
            r_done   <= 1'b1;
          end
          r_cnt <= '0;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign stall    = w_accept | r_busy;
  assign resultLo = r_res_lo;
  assign resultHi = r_res_hi;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: vector table plus reset/flush/busy-start sequences.
module tb_ex_muldiv;
  import lapido_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] resultLo;
  logic [31:0] resultHi;

  int n_tests = 0;
  int n_fail  = 0;

  ex_muldiv dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operandA(operandA), .operandB(operandB), .flush(flush),
    .busy(busy), .stall(stall), .done(done),
    .resultLo(resultLo), .resultHi(resultHi)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at #1 after a posedge; accept happens on the next posedge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; operandA = a; operandB = b;
    #1;
    check("stall_on_start", stall, 1);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Counts edges after accept until done; optionally pokes start while busy.
  task automatic wait_done(input string name, input int poke_cyc, output int lat);
    logic busy_ok;
    busy_ok = 1'b1;
    lat = 0;
    if (!(busy && stall)) busy_ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (lat == poke_cyc && poke_cyc != 0) begin
        start = 1'b1; op = MD_MULU; operandA = 32'd1; operandB = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      lat++;
      if (done) break;
      if (!(busy && stall)) busy_ok = 1'b0;
    end
    start = 1'b0;
    check({name, "_busy_stall_held"}, busy_ok, 1);
    check({name, "_busy_low_at_done"}, busy, 0);
  endtask

  task automatic watch_idle(input string name, input int cycles);
    int n_done;
    int n_busy;
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      if (done) n_done++;
      if (busy) n_busy++;
    end
    check({name, "_no_done"}, n_done, 0);
    check({name, "_stays_idle"}, n_busy, 0);
  endtask

  initial begin
    int lat;
    logic [31:0] prev_lo, prev_hi;

    vecs[0]  = '{"mulu_max",     MD_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 33};
    vecs[1]  = '{"mul_neg3x7",   MD_MUL,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 33};
    vecs[2]  = '{"div_neg7_2",   MD_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 33};
    vecs[3]  = '{"divu_100_7",   MD_DIVU, 32'd100,      32'd7,        32'd14,       32'd2,        33};
    vecs[4]  = '{"divu_by_zero", MD_DIVU, 32'd100,      32'd0,        32'hFFFFFFFF, 32'd100,      1};
    vecs[5]  = '{"div_overflow", MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 33};
    vecs[6]  = '{"mulu_shift",   MD_MULU, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 33};
    vecs[7]  = '{"mul_min_sq",   MD_MUL,  32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 33};
    vecs[8]  = '{"mul_zero_neg", MD_MUL,  32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 33};
    vecs[9]  = '{"div_7_neg2",   MD_DIV,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 33};
    vecs[10] = '{"div_neg7_neg2",MD_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 33};
    vecs[11] = '{"div_by_zero_s",MD_DIV,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFB, 1};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_stall", stall, 0);
    check("reset_lo", resultLo, 0);
    check("reset_hi", resultHi, 0);
    @(posedge clock); #1;

    // Back-to-back: each new start is issued in the cycle done is high.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].name, 0, lat);
      check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      check({vecs[i].name, "_lo"}, resultLo, vecs[i].lo);
      check({vecs[i].name, "_hi"}, resultHi, vecs[i].hi);
      $display("[TB] %s: lat=%0d lo=0x%08h hi=0x%08h", vecs[i].name, lat, resultLo, resultHi);
    end

    // Reset in the middle of a multiply.
    issue(MD_MUL, 32'hFFFFFFFD, 32'd7);
    begin
      int n_done;
      n_done = 0;
      for (int i = 0; i < 9; i++) begin
        @(posedge clock); #1;
        if (done) n_done++;
      end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("rst_mid_no_done", n_done + int'(done), 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_lo", resultLo, 0);
      check("rst_mid_hi", resultHi, 0);
    end
    issue(MD_MULU, 32'd3, 32'd5);
    wait_done("after_reset", 0, lat);
    check("after_reset_latency", lat, 33);
    check("after_reset_lo", resultLo, 32'd15);
    check("after_reset_hi", resultHi, 32'd0);
    $display("[TB] reset mid-op then mulu 3x5: lo=0x%08h", resultLo);

    // Flush during a divide.
    prev_lo = resultLo;
    prev_hi = resultHi;
    @(posedge clock); #1;
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (4) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_run_busy", busy, 0);
    check("flush_run_done", done, 0);
    watch_idle("flush_run", 40);
    check("flush_run_lo_kept", resultLo, prev_lo);
    check("flush_run_hi_kept", resultHi, prev_hi);
    $display("[TB] flush in RUN: busy=%0b lo=0x%08h", busy, resultLo);

    // Flush coincident with start drops the start.
    start = 1'b1; op = MD_DIVU; operandA = 32'd50; operandB = 32'd5;
    flush = 1'b1;
    #1;
    check("flush_start_stall", stall, 0);
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", busy, 0);
    watch_idle("flush_start", 40);
    check("flush_start_lo_kept", resultLo, prev_lo);
    $display("[TB] flush with start: busy=%0b lo=0x%08h", busy, resultLo);

    // A start pulsed while busy must not disturb the running op.
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_done("start_while_busy", 10, lat);
    check("start_while_busy_latency", lat, 33);
    check("start_while_busy_lo", resultLo, 32'd14);
    check("start_while_busy_hi", resultHi, 32'd2);
    @(posedge clock); #1;
    check("start_while_busy_idle_after", busy, 0);
    $display("[TB] start while busy: lat=%0d lo=0x%08h hi=0x%08h", lat, resultLo, resultHi);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
